bcd_to_bin_converter: RTL and testbench

Sequential converter from packed BCD to binary. It takes six BCD digits (for example a stored or operator-entered millisecond time) and returns the binary value, so the game FSM can compare it against the ms counters. It is the inverse of hex_to_bcd_converter. The algorithm is iterative reverse double-dabble: one shift per clock, with a start/busy/done handshake.

---
 rtl/bcd_to_bin_converter.sv | 67 ++++++
 tb/tb_bcd_to_bin_converter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter: iterative reverse double-dabble BCD->binary; in clk/reset/start/bcd_in, out bin_out/busy/done/error
module bcd_to_bin_converter #(
  parameter int DIGITS = 6,
  parameter int BIN_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]    bin_out,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int IW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state;
  logic [4*DIGITS-1:0] bcd_sr, bcd_sh, bcd_nx;
  logic [BIN_W-1:0] bin_sr, bin_nx;
  logic [IW-1:0] iter;
  logic bad;
  always_comb begin
    bcd_sh = bcd_sr >> 1;
    bin_nx = {bcd_sr[0], bin_sr[BIN_W-1:1]};
    bcd_nx = bcd_sh;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_nx[4*i+:4] = bcd_sh[4*i+3] ? bcd_sh[4*i+:4] - 4'd3 : bcd_sh[4*i+:4];
      bad = bad | (bcd_in[4*i+:4] > 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcd_sr <= '0;
      bin_sr <= '0;
      iter <= '0;
      bin_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      if (state == IDLE) begin
        if (start && bad) error <= 1'b1;
        else if (start) begin
          bcd_sr <= bcd_in;
          bin_sr <= '0;
          iter <= '0;
          busy <= 1'b1;
          state <= CONVERT;
        end
      end else begin
        bcd_sr <= bcd_nx;
        bin_sr <= bin_nx;
        iter <= iter + 1'b1;
        if (iter == IW'(BIN_W - 1)) begin
          bin_out <= bin_nx;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// tb_bcd_to_bin_converter: directed self-checking bench for bcd_to_bin_converter
module tb_bcd_to_bin_converter;
  logic clk = 1'b0;
  logic reset, start;
  logic [23:0] bcd_in;
  logic [19:0] bin_out;
  logic busy, done, error;
  int total = 0;
  int bad = 0;
  bcd_to_bin_converter dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag, output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [23:0] b, input logic [19:0] exp);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, lat, bcnt);
    chk({tag, "_lat"}, lat, 21);
    chk({tag, "_busy_cycles"}, bcnt, 20);
    chk({tag, "_bin"}, bin_out, exp);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_err_at_done"}, error, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask
  initial begin
    int lat, bcnt, dcnt;
    reset = 1'b1;
    start = 1'b1;
    bcd_in = 24'h123456;
    repeat (3) @(negedge clk);
    chk("rst_bin", bin_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    run("c123456", 24'h123456, 20'h1E240);
    run("c999999", 24'h999999, 20'hF423F);
    run("c000000", 24'h000000, 20'h00000);
    run("c123456b", 24'h123456, 20'h1E240);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 24'h00A123;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", error, 1);
    chk("err_busy", busy, 0);
    chk("err_done", done, 0);
    @(negedge clk);
    chk("err_one_cycle", error, 0);
    chk("err_busy2", busy, 0);
    chk("err_bin_hold", bin_out, 20'h1E240);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 24'h007000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_busy5", busy, 1);
    start = 1'b1;
    bcd_in = 24'h000001;
    @(negedge clk);
    start = 1'b0;
    bcd_in = 24'h000000;
    wait_done("ign", lat, bcnt);
    chk("ign_lat", lat, 16);
    chk("ign_bin", bin_out, 20'h01B58);
    dcnt = 0;
    bcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("ign_no_second_done", dcnt, 0);
    chk("ign_no_second_busy", bcnt, 0);
    chk("ign_bin_hold", bin_out, 20'h01B58);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 24'h005000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rmid_busy10", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_bin", bin_out, 0);
    chk("rmid_done", done, 0);
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("rmid_quiet", dcnt, 0);
    run("c000250", 24'h000250, 20'd250);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 24'h000042;
    for (int c = 1; c <= 63; c++) begin
      @(negedge clk);
      if (c == 63) start = 1'b0;
      chk($sformatf("held_done_c%0d", c), done, (c % 21) == 0);
      chk($sformatf("held_busy_c%0d", c), busy, (c % 21) != 0);
      if (c % 21 == 0) chk($sformatf("held_bin_c%0d", c), bin_out, 20'd42);
    end
    @(negedge clk);
    chk("held_stop_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
